store_buffer: RTL and testbench

- Write-side counterpart of the WB-stage load extractor.
- Accepts committed stores from the MEM stage and checks alignment.
- Replicates the store data into lanes and generates byte strobes.
- Queues stores in a small FIFO and drains them one at a time onto the sram-like data bus (req/addr_ok/data_ok).
- Also reports word-address hits so the hazard unit can stall dependent loads.

---
 rtl/store_buffer_pkg.sv | 28 ++
 rtl/store_buffer_if.sv | 23 ++
 rtl/store_align.sv | 42 ++++
 rtl/store_buffer.sv | 128 ++++++++++++
 tb/tb_store_buffer.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared CPU definitions for the store path: store sizes, bus size codes,
// the queued-store entry and the drain FSM encoding.
package CPU_Defines;

  typedef enum logic [1:0] {
    STORETYPE_SB = 2'd0,
    STORETYPE_SH = 2'd1,
    STORETYPE_SW = 2'd2
  } StoreType;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_REQ  = 2'd1,
    SB_WAIT = 2'd2
  } sb_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// SRAM-like write bus between the store buffer (master) and memory (slave).
// data_req_o is held with stable payload until data_addr_ok_i; data_data_ok_i
// marks completion and never arrives in the same cycle as data_addr_ok_i.
interface store_buffer_if;
  logic        data_req_o;
  logic        data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_wstrb_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;

  modport master (
    output data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, data_wstrb_o,
    input  data_addr_ok_i, data_data_ok_i
  );

  modport slave (
    input  data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, data_wstrb_o,
    output data_addr_ok_i, data_data_ok_i
  );
endinterface

// File: rtl/store_align.sv
// Combinational store alignment: lane replication, byte strobes, bus size
// code and the misaligned-store exception flag.
module store_align
  import CPU_Defines::*;
(
  input  logic        valid,
  input  StoreType    store_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [1:0]  size,
  output logic        ades
);

  logic misaligned;

  always_comb begin
    wdata      = data;
    wstrb      = 4'b1111;
    size       = SIZE_WORD;
    misaligned = (addr_lo != 2'b00);
    case (store_type)
      STORETYPE_SB: begin
        wdata      = {4{data[7:0]}};
        wstrb      = 4'b0001 << addr_lo;
        size       = SIZE_BYTE;
        misaligned = 1'b0;
      end
      STORETYPE_SH: begin
        wdata      = {2{data[15:0]}};
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        size       = SIZE_HALF;
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

  assign ades = valid & misaligned;

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO draining one write at a time onto the data bus.
// Optional macro SB_STALL_CNT_EN builds a saturating store-stall cycle counter.
module store_buffer
  import CPU_Defines::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_StoreValid_i,
  input  StoreType    MEM_StoreType_i,
  input  logic [31:0] MEM_Addr_i,
  input  logic [31:0] MEM_StoreData_i,
  output logic        MEM_StoreReady_o,
  output logic        MEM_AdES_o,
  input  logic [31:0] LD_Addr_i,
  output logic        LD_Hit_o,
  output logic        SB_Empty_o,
  store_buffer_if.master bus,
  output logic [31:0] SB_StallCnt_o,
  output sb_state_t   dbg_state
);

  sb_entry_t        mem [DEPTH];
  sb_entry_t        head, new_entry;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, off;
  logic [PTR_W:0]   count;
  sb_state_t        state, state_nxt;
  logic [31:0]      al_wdata;
  logic [3:0]       al_wstrb;
  logic [1:0]       al_size;
  logic             full, push, pop;
  logic             unused_ld;

  store_align u_align (
    .valid      (MEM_StoreValid_i),
    .store_type (MEM_StoreType_i),
    .addr_lo    (MEM_Addr_i[1:0]),
    .data       (MEM_StoreData_i),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .size       (al_size),
    .ades       (MEM_AdES_o)
  );

  assign full             = (count == (PTR_W+1)'(DEPTH));
  assign MEM_StoreReady_o = !full;
  assign push             = MEM_StoreValid_i & !full & !MEM_AdES_o;
  assign pop              = (state == SB_WAIT) & bus.data_data_ok_i;
  assign head             = mem[rd_ptr];
  assign new_entry        = '{addr: MEM_Addr_i, wdata: al_wdata, wstrb: al_wstrb, size: al_size};
  assign unused_ld        = &{1'b0, LD_Addr_i[1:0]};

  // Payloads carry no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SB_IDLE;
    else     state <= state_nxt;
  end

  // Leaving IDLE on a same-cycle push lets a store reach the bus one cycle later.
  always_comb begin
    state_nxt = state;
    case (state)
      SB_IDLE: if (count != '0 || push) state_nxt = SB_REQ;
      SB_REQ:  if (bus.data_addr_ok_i) state_nxt = SB_WAIT;
      SB_WAIT: if (bus.data_data_ok_i)
                 state_nxt = (count > (PTR_W+1)'(1)) ? SB_REQ : SB_IDLE;
      default: state_nxt = SB_IDLE;
    endcase
  end

  always_comb begin
    bus.data_req_o   = (state == SB_REQ);
    bus.data_wr_o    = 1'b1;
    bus.data_size_o  = head.size;
    bus.data_addr_o  = head.addr;
    bus.data_wdata_o = head.wdata;
    bus.data_wstrb_o = head.wstrb;
    SB_Empty_o       = (count == '0) & (state == SB_IDLE);
    dbg_state        = state;
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    LD_Hit_o = 1'b0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (({1'b0, off} < count) && (mem[i].addr[31:2] == LD_Addr_i[31:2]))
        LD_Hit_o = 1'b1;
    end
  end

`ifdef SB_STALL_CNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (MEM_StoreValid_i & full & ~&stall_cnt)
      stall_cnt <= stall_cnt + 32'd1;
  end
  assign SB_StallCnt_o = stall_cnt;
`else
  assign SB_StallCnt_o = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: alignment vector table, hand-written bus/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_store_buffer;
  import CPU_Defines::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  size;
  } exp_t;

  typedef struct {
    StoreType    t;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  size;
    logic        ades;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        store_valid;
  StoreType    store_type;
  logic [31:0] store_addr, store_data, ld_addr;
  logic        store_ready, ades, ld_hit, sb_empty;
  logic [31:0] stall_cnt;
  sb_state_t   dbg_state;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .MEM_StoreValid_i (store_valid),
    .MEM_StoreType_i  (store_type),
    .MEM_Addr_i       (store_addr),
    .MEM_StoreData_i  (store_data),
    .MEM_StoreReady_o (store_ready),
    .MEM_AdES_o       (ades),
    .LD_Addr_i        (ld_addr),
    .LD_Hit_o         (ld_hit),
    .SB_Empty_o       (sb_empty),
    .bus              (bus),
    .SB_StallCnt_o    (stall_cnt),
    .dbg_state        (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input StoreType t);
    return (t == STORETYPE_SB) ? 1 : (t == STORETYPE_SH) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input StoreType t, input logic [31:0] a);
    return (a % nbytes(t)) != 0;
  endfunction

  function automatic exp_t model_entry(input StoreType t, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   n = nbytes(t);
    e.addr = a;
    e.strb = 4'(((1 << n) - 1) << (a % 4));
    if (n == 1)      begin e.wdata = d[7:0] * 32'h0101_0101;  e.size = 2'd0; end
    else if (n == 2) begin e.wdata = d[15:0] * 32'h0001_0001; e.size = 2'd1; end
    else             begin e.wdata = d;                       e.size = 2'd2; end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    store_valid = 1'b0;
    bus.data_addr_ok_i = 1'b0;
    bus.data_data_ok_i = 1'b0;
    ld_addr = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_bus(input string tag, input logic [31:0] ea, input logic [31:0] ew,
                           input logic [3:0] es, input logic [1:0] esz);
    check({tag, " req"},   bus.data_req_o, 1);
    check({tag, " addr"},  bus.data_addr_o, ea);
    check({tag, " wdata"}, bus.data_wdata_o, ew);
    check({tag, " wstrb"}, bus.data_wstrb_o, es);
    check({tag, " size"},  bus.data_size_o, esz);
  endtask

  // Called at a negedge; returns at the negedge right after the pop edge.
  task automatic drain_one(input string tag, input logic [31:0] ea, input logic [31:0] ew,
                           input logic [3:0] es, input logic [1:0] esz,
                           input int delay, input bit immediate);
    int waited = 0;
    #1;
    if (immediate) check({tag, " req_now"}, bus.data_req_o, 1);
    else begin
      while (!bus.data_req_o && waited < 8) begin
        @(negedge clk); #1; waited++;
      end
      check({tag, " req_wait"}, bus.data_req_o, 1);
    end
    for (int k = 0; k < delay; k++) begin
      bus.data_addr_ok_i = 1'b0;
      check_bus({tag, " hold"}, ea, ew, es, esz);
      @(negedge clk); #1;
    end
    check_bus(tag, ea, ew, es, esz);
    check({tag, " wr"}, bus.data_wr_o, 1);
    bus.data_addr_ok_i = 1'b1;
    @(negedge clk);
    bus.data_addr_ok_i = 1'b0;
    #1;
    check({tag, " req_in_wait"}, bus.data_req_o, 0);
    bus.data_data_ok_i = 1'b1;
    @(negedge clk);
    bus.data_data_ok_i = 1'b0;
  endtask

  task automatic drive_store(input StoreType t, input logic [31:0] a, input logic [31:0] d);
    store_valid = 1'b1;
    store_type  = t;
    store_addr  = a;
    store_data  = d;
  endtask

  // ---------------- main test ----------------
  vec_t vecs[8];
  bit   pending;
  int   lag;
  int   exp_stall;

  initial begin
    store_type = STORETYPE_SW;
    store_addr = '0;
    store_data = '0;

    vecs[0] = '{STORETYPE_SB, 32'h0000_1003, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000, 2'd0, 1'b0};
    vecs[1] = '{STORETYPE_SH, 32'h0000_2002, 32'h1234_BEEF, 32'hBEEF_BEEF, 4'b1100, 2'd1, 1'b0};
    vecs[2] = '{STORETYPE_SH, 32'h0000_2001, 32'h1234_BEEF, 32'h0,         4'b0000, 2'd1, 1'b1};
    vecs[3] = '{STORETYPE_SW, 32'h0000_3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 2'd2, 1'b0};
    vecs[4] = '{STORETYPE_SW, 32'h0000_3002, 32'hDEAD_BEEF, 32'h0,         4'b0000, 2'd2, 1'b1};
    vecs[5] = '{STORETYPE_SB, 32'h0000_1000, 32'h1234_5678, 32'h7878_7878, 4'b0001, 2'd0, 1'b0};
    vecs[6] = '{STORETYPE_SH, 32'h0000_2000, 32'hCAFE_1234, 32'h1234_1234, 4'b0011, 2'd1, 1'b0};
    vecs[7] = '{STORETYPE_SB, 32'h0000_1001, 32'h0000_00FF, 32'hFFFF_FFFF, 4'b0010, 2'd0, 1'b0};

    // Reset values, sampled while rst is still held.
    rst = 1'b1;
    store_valid = 1'b0;
    bus.data_addr_ok_i = 1'b0;
    bus.data_data_ok_i = 1'b0;
    ld_addr = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst req",   bus.data_req_o, 0);
    check("rst ready", store_ready, 1);
    check("rst empty", sb_empty, 1);
    check("rst hit",   ld_hit, 0);
    check("rst stall", stall_cnt, 0);
    check("rst state", 32'(dbg_state), 32'(SB_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Alignment table: each store goes through a full bus transaction.
    for (int i = 0; i < 8; i++) begin
      drive_store(vecs[i].t, vecs[i].addr, vecs[i].data);
      #1;
      check($sformatf("vec%0d ades", i), ades, vecs[i].ades);
      @(negedge clk);
      store_valid = 1'b0;
      if (vecs[i].ades) begin
        #1;
        check($sformatf("vec%0d no_req", i), bus.data_req_o, 0);
        check($sformatf("vec%0d empty", i), sb_empty, 1);
        @(negedge clk);
      end else begin
        drain_one($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                  vecs[i].size, i % 3, 1'b1);
        #1;
        check($sformatf("vec%0d empty_after", i), sb_empty, 1);
      end
    end

    // Fill with addr_ok low, then hold a fifth store off for three cycles.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_store(STORETYPE_SW, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      #1;
      check($sformatf("fill%0d ready", i), store_ready, 1);
      @(negedge clk);
    end
    drive_store(STORETYPE_SW, 32'h110, 32'hC0DE_0004);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("full%0d ready", k), store_ready, 0);
      @(negedge clk);
    end
    store_valid = 1'b0;
    #1;
`ifdef SB_STALL_CNT_EN
    check("stall count", stall_cnt, 3);
`else
    check("stall count", stall_cnt, 0);
`endif
    for (int i = 0; i < DEPTH; i++)
      drain_one($sformatf("drain%0d", i), 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i),
                4'b1111, 2'd2, (i == 0) ? 3 : 1, 1'b1);
    #1;
    check("drain empty", sb_empty, 1);
    check("drain ready", store_ready, 1);

    // Load hazard hits against a queued word.
    do_reset();
    drive_store(STORETYPE_SW, 32'h3000, 32'h5555_AAAA);
    @(negedge clk);
    store_valid = 1'b0;
    ld_addr = 32'h3002;
    #1;
    check("hit same word", ld_hit, 1);
    ld_addr = 32'h3004;
    #1;
    check("hit next word", ld_hit, 0);
    ld_addr = 32'h3000;
    drain_one("hit drain", 32'h3000, 32'h5555_AAAA, 4'b1111, 2'd2, 0, 1'b1);
    #1;
    check("hit after pop", ld_hit, 0);
    check("hit empty", sb_empty, 1);

    // Reset while waiting for data_ok with two entries queued.
    do_reset();
    drive_store(STORETYPE_SW, 32'h500, 32'h1);
    @(negedge clk);
    drive_store(STORETYPE_SW, 32'h504, 32'h2);
    @(negedge clk);
    store_valid = 1'b0;
    bus.data_addr_ok_i = 1'b1;
    #1;
    check("rstw req", bus.data_req_o, 1);
    @(negedge clk);
    bus.data_addr_ok_i = 1'b0;
    #1;
    check("rstw in wait", 32'(dbg_state), 32'(SB_WAIT));
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rstw state", 32'(dbg_state), 32'(SB_IDLE));
    check("rstw req0", bus.data_req_o, 0);
    check("rstw empty", sb_empty, 1);
    check("rstw ready", store_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rstw stays idle", bus.data_req_o, 0);

    // Randomized traffic against the queue model.
    do_reset();
    exp_q.delete();
    pending = 1'b0;
    lag = 0;
    exp_stall = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit   m_ready, m_ades, m_hit;
      exp_t front;
      store_valid = ($urandom_range(0, 3) != 0);
      store_type  = StoreType'($urandom_range(0, 2));
      store_addr  = 32'h4000 + 32'($urandom_range(0, 31));
      store_data  = $urandom;
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
        ld_addr = exp_q[$urandom_range(0, exp_q.size() - 1)].addr ^ 32'($urandom_range(0, 3));
      else
        ld_addr = 32'h4000 + 32'($urandom_range(0, 35));
      bus.data_data_ok_i = pending && ($urandom_range(0, 2) == 0);
      bus.data_addr_ok_i = !pending && ($urandom_range(0, 2) == 0);
      #1;
      m_ready = exp_q.size() < DEPTH;
      m_ades  = store_valid && model_misaligned(store_type, store_addr);
      m_hit   = 1'b0;
      foreach (exp_q[j]) if (exp_q[j].addr[31:2] == ld_addr[31:2]) m_hit = 1'b1;
      check("rnd ready", store_ready, m_ready);
      check("rnd ades",  ades, m_ades);
      check("rnd hit",   ld_hit, m_hit);
      check("rnd empty", sb_empty, exp_q.size() == 0);
      check("rnd stall", stall_cnt,
`ifdef SB_STALL_CNT_EN
            32'(exp_stall)
`else
            32'd0
`endif
      );
      if (bus.data_req_o) begin
        check("rnd req_while_pending", pending, 0);
        check("rnd req_with_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          front = exp_q[0];
          check("rnd addr",  bus.data_addr_o, front.addr);
          check("rnd wdata", bus.data_wdata_o, front.wdata);
          check("rnd wstrb", bus.data_wstrb_o, front.strb);
          check("rnd size",  bus.data_size_o, front.size);
        end
        lag = 0;
      end else if (!pending && exp_q.size() > 0) begin
        lag++;
        check("rnd issue_lag", lag <= 2, 1);
      end else lag = 0;
      // Model update for the coming edge.
      if (store_valid && !m_ready) exp_stall++;
      if (pending && bus.data_data_ok_i) begin
        void'(exp_q.pop_front());
        pending = 1'b0;
      end else if (bus.data_req_o && bus.data_addr_ok_i) pending = 1'b1;
      if (store_valid && m_ready && !m_ades)
        exp_q.push_back(model_entry(store_type, store_addr, store_data));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
